// File: rtl/riscv_rf_pkg.sv
// Shared definitions for the multi-port register file: default geometry,
// reset level and the per-register scoreboard action encoding.
package riscv_rf_pkg;

  // Default geometry of the integer register file.
  localparam int RF_DW  = 32;
  localparam int RF_AW  = 5;
  localparam int RF_NRD = 2;

  // Level of rst_i that holds the block in reset (active-low).
  localparam logic RESET_ON = 1'b0;

  // What the scoreboard does to one busy bit at the next clock edge.
  typedef enum logic [1:0] {
    SB_HOLD  = 2'd0,
    SB_SET   = 2'd1,
    SB_CLEAR = 2'd2
  } sb_op_e;

endpackage

// File: rtl/riscv_rf_scoreboard.sv
// Per-register busy scoreboard. Flush beats issue, issue beats writeback,
// so the newest producer of a register always owns its busy bit.
module riscv_rf_scoreboard
  import riscv_rf_pkg::*;
#(
  parameter int AW      = RF_AW,
  parameter int ZERO_R0 = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                iss_i,
  input  logic [AW-1:0]       iss_idx_i,
  input  logic                wr_i,
  input  logic [AW-1:0]       wr_idx_i,
  input  logic                flush_i,
  output logic [(2**AW)-1:0]  busy_o,
  output logic                busy_any_o
);

  localparam int DEPTH = 2 ** AW;

  logic [DEPTH-1:0] busy_reg;
  logic [DEPTH-1:0] busy_next;
  logic             busy_any_reg;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_bit
      sb_op_e op;

      // Resolve flush > issue > writeback for this register; r0 is never set when hardwired.
      always_comb begin
        op = SB_HOLD;
        if (flush_i) begin
          op = SB_CLEAR;
        end else if (iss_i && (iss_idx_i == AW'(gi)) && !((ZERO_R0 != 0) && (gi == 0))) begin
          op = SB_SET;
        end else if (wr_i && (wr_idx_i == AW'(gi))) begin
          op = SB_CLEAR;
        end
      end

      assign busy_next[gi] = (op == SB_SET)   ? 1'b1 :
                             (op == SB_CLEAR) ? 1'b0 : busy_reg[gi];
    end
  endgenerate

  // Busy vector and its OR summary are both registered so busy_any_o never sees same-cycle events.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (rst_i == RESET_ON) begin
      busy_reg     <= '0;
      busy_any_reg <= 1'b0;
    end else begin
      busy_reg     <= busy_next;
      busy_any_reg <= |busy_next;
    end
  end

  assign busy_o     = busy_reg;
  assign busy_any_o = busy_any_reg;

endmodule

// File: rtl/riscv_regfile_mp.sv
// Multi-read-port integer register file with optional write-to-read
// bypass, busy scoreboard and a non-bypassed debug read port.
module riscv_regfile_mp
  import riscv_rf_pkg::*;
#(
  parameter int DW      = RF_DW,
  parameter int AW      = RF_AW,
  parameter int NRD     = RF_NRD,
  parameter int BYPASS  = 1,
  parameter int ZERO_R0 = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [NRD*AW-1:0]   rd_idx_i,
  output logic [NRD*DW-1:0]   rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic                wr_i,
  input  logic [AW-1:0]       wr_idx_i,
  input  logic [DW-1:0]       wr_data_i,
  input  logic                iss_i,
  input  logic [AW-1:0]       iss_idx_i,
  input  logic                flush_i,
  output logic                busy_any_o,
  input  logic [AW-1:0]       dbg_idx_i,
  output logic [DW-1:0]       dbg_data_o
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0]    mem_reg [DEPTH];
  logic [DEPTH-1:0] busy;
  logic             wr_allowed;

  // Writes to a hardwired r0 are dropped so it always reads back as zero.
  assign wr_allowed = wr_i && !((ZERO_R0 != 0) && (wr_idx_i == '0));

  // Storage array; cleared on reset so every read port starts at zero.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (rst_i == RESET_ON) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else if (wr_allowed) begin
      mem_reg[wr_idx_i] <= wr_data_i;
    end
  end

  riscv_rf_scoreboard #(
    .AW      (AW),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .iss_i      (iss_i),
    .iss_idx_i  (iss_idx_i),
    .wr_i       (wr_i),
    .wr_idx_i   (wr_idx_i),
    .flush_i    (flush_i),
    .busy_o     (busy),
    .busy_any_o (busy_any_o)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0] idx;
      logic          wr_hit;
      logic          iss_hit;
      logic [DW-1:0] data;

      assign idx     = rd_idx_i[gi*AW +: AW];
      assign wr_hit  = (BYPASS != 0) && wr_i && (wr_idx_i == idx);
      assign iss_hit = iss_i && (iss_idx_i == idx);

      // Operand mux: hardwired zero, then same-cycle writeback, then stored value.
      always_comb begin
        data = mem_reg[idx];
        if ((ZERO_R0 != 0) && (idx == '0)) begin
          data = '0;
        end else if (wr_hit) begin
          data = wr_data_i;
        end
      end

      assign rd_data_o[gi*DW +: DW] = data;
      // A forwarded result is reported ready unless a newer issue reclaims the register this cycle.
      assign rd_busy_o[gi] = busy[idx] & ~(wr_hit & ~iss_hit);
    end
  endgenerate

  // The monitor sees committed state only.
  assign dbg_data_o = mem_reg[dbg_idx_i];

endmodule

// File: tb/tb_riscv_regfile_mp.sv
// Self-checking bench: two register file configurations share one stimulus
// stream and are compared against an array-based reference model.
module tb_riscv_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [4:0]   ra [4];
  logic [9:0]   rd_idx_a;
  logic [19:0]  rd_idx_b;
  logic [63:0]  rd_data_a;
  logic [1:0]   rd_busy_a;
  logic [255:0] rd_data_b;
  logic [3:0]   rd_busy_b;
  logic         wr;
  logic [4:0]   wr_idx;
  logic [63:0]  wr_data;
  logic         iss;
  logic [4:0]   iss_idx;
  logic         flush;
  logic [4:0]   dbg_idx;
  logic         busy_any_a, busy_any_b;
  logic [31:0]  dbg_a;
  logic [63:0]  dbg_b;

  assign rd_idx_a = {ra[1], ra[0]};
  assign rd_idx_b = {ra[3], ra[2], ra[1], ra[0]};

  riscv_regfile_mp #(.DW(32), .AW(5), .NRD(2), .BYPASS(1), .ZERO_R0(1)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .rd_idx_i(rd_idx_a), .rd_data_o(rd_data_a), .rd_busy_o(rd_busy_a),
    .wr_i(wr), .wr_idx_i(wr_idx), .wr_data_i(wr_data[31:0]), .iss_i(iss), .iss_idx_i(iss_idx),
    .flush_i(flush), .busy_any_o(busy_any_a), .dbg_idx_i(dbg_idx), .dbg_data_o(dbg_a)
  );

  riscv_regfile_mp #(.DW(64), .AW(5), .NRD(4), .BYPASS(0), .ZERO_R0(1)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .rd_idx_i(rd_idx_b), .rd_data_o(rd_data_b), .rd_busy_o(rd_busy_b),
    .wr_i(wr), .wr_idx_i(wr_idx), .wr_data_i(wr_data), .iss_i(iss), .iss_idx_i(iss_idx),
    .flush_i(flush), .busy_any_o(busy_any_b), .dbg_idx_i(dbg_idx), .dbg_data_o(dbg_b)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: committed register contents and pending-write flags.
  logic [63:0] m_reg  [32];
  bit          m_busy [32];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] exp_rd(input logic [4:0] idx, input bit byp);
    if (idx == 5'd0) return 64'd0;
    if (byp && wr && wr_idx == idx) return wr_data;
    return m_reg[idx];
  endfunction

  function automatic logic exp_busy(input logic [4:0] idx, input bit byp);
    if (!m_busy[idx]) return 1'b0;
    if (byp && wr && wr_idx == idx && !(iss && iss_idx == idx)) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic exp_any();
    for (int i = 0; i < 32; i++) if (m_busy[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = 64'd0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Apply the edge to the model: data first, then scoreboard with flush/issue/writeback priority.
  task automatic model_edge();
    if (wr && wr_idx != 5'd0) m_reg[wr_idx] = wr_data;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else begin
      if (wr) m_busy[wr_idx] = 1'b0;
      if (iss && iss_idx != 5'd0) m_busy[iss_idx] = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("%s/a_rd%0d", tag, k), {32'd0, rd_data_a[k*32 +: 32]},
          exp_rd(ra[k], 1'b1) & 64'h0000_0000_FFFF_FFFF);
      chk($sformatf("%s/a_busy%0d", tag, k), {63'd0, rd_busy_a[k]}, {63'd0, exp_busy(ra[k], 1'b1)});
    end
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("%s/b_rd%0d", tag, k), rd_data_b[k*64 +: 64], exp_rd(ra[k], 1'b0));
      chk($sformatf("%s/b_busy%0d", tag, k), {63'd0, rd_busy_b[k]}, {63'd0, exp_busy(ra[k], 1'b0)});
    end
    chk({tag, "/a_any"}, {63'd0, busy_any_a}, {63'd0, exp_any()});
    chk({tag, "/b_any"}, {63'd0, busy_any_b}, {63'd0, exp_any()});
    chk({tag, "/a_dbg"}, {32'd0, dbg_a}, m_reg[dbg_idx] & 64'h0000_0000_FFFF_FFFF);
    chk({tag, "/b_dbg"}, dbg_b, m_reg[dbg_idx]);
  endtask

  // Called just after a falling edge with inputs applied; returns at the next falling edge.
  task automatic step(input string tag);
    #1;
    check_all(tag);
    @(posedge clk);
    if (rst_n) model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input bit w, input logic [4:0] wi, input logic [63:0] wd,
                       input bit is, input logic [4:0] ii, input bit fl);
    wr = w; wr_idx = wi; wr_data = wd; iss = is; iss_idx = ii; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    for (int k = 0; k < 4; k++) ra[k] = 5'd0;
    dbg_idx = 5'd0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step("reset_state");

    // T1: load r5, mark it busy, then drop reset between edges.
    ra[0] = 5'd5; dbg_idx = 5'd5;
    drive(1'b1, 5'd5, 64'hDEAD, 1'b0, 5'd0, 1'b0);
    step("t1_wr");
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd5, 1'b0);
    step("t1_iss");
    idle();
    #1;
    chk("t1_pre_rd", {32'd0, rd_data_a[31:0]}, 64'hDEAD);
    chk("t1_pre_busy", {62'd0, rd_busy_a}, 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t1_rst_rd_a", {32'd0, rd_data_a[31:0]}, 64'd0);
    chk("t1_rst_rd_b", rd_data_b[63:0], 64'd0);
    chk("t1_rst_busy", {62'd0, rd_busy_a}, 64'd0);
    chk("t1_rst_any", {63'd0, busy_any_a}, 64'd0);
    chk("t1_rst_dbg", dbg_b, 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    $display("t1 reset mid-cycle done");
    step("t1_after");

    // T2: writes and issues aimed at r0 have no effect.
    ra[0] = 5'd0; dbg_idx = 5'd0;
    drive(1'b1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 5'd0, 1'b0);
    #1;
    chk("t2_rd0_same", {32'd0, rd_data_a[31:0]}, 64'd0);
    step("t2_wr0");
    idle();
    #1;
    chk("t2_rd0_after", {32'd0, rd_data_a[31:0]}, 64'd0);
    chk("t2_busy0", {62'd0, rd_busy_a}, 64'd0);
    chk("t2_any", {63'd0, busy_any_a}, 64'd0);
    $display("t2 x0 done");
    step("t2_idle");

    // T3: bypass on config A, stored value on config B until the edge.
    ra[0] = 5'd7; dbg_idx = 5'd7;
    drive(1'b1, 5'd7, 64'h1234, 1'b0, 5'd0, 1'b0);
    #1;
    chk("t3_byp_a", {32'd0, rd_data_a[31:0]}, 64'h1234);
    chk("t3_nobyp_b", rd_data_b[63:0], 64'd0);
    step("t3_wr");
    idle();
    #1;
    chk("t3_after_b", rd_data_b[63:0], 64'h1234);
    $display("t3 bypass done");
    step("t3_idle");

    // T4: issue r3, then write it back.
    ra[1] = 5'd3;
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 1'b0);
    step("t4_iss");
    idle();
    #1;
    chk("t4_busy", {63'd0, rd_busy_a[1]}, 64'd1);
    chk("t4_any", {63'd0, busy_any_a}, 64'd1);
    step("t4_wait");
    drive(1'b1, 5'd3, 64'h33, 1'b0, 5'd0, 1'b0);
    #1;
    chk("t4_wb_byp_a", {63'd0, rd_busy_a[1]}, 64'd0);
    chk("t4_wb_nobyp_b", {63'd0, rd_busy_b[1]}, 64'd1);
    chk("t4_wb_any", {63'd0, busy_any_a}, 64'd1);
    step("t4_wb");
    idle();
    #1;
    chk("t4_clr", {63'd0, rd_busy_a[1]}, 64'd0);
    chk("t4_clr_any", {63'd0, busy_any_a}, 64'd0);
    $display("t4 scoreboard done");
    step("t4_idle");

    // T5: issue and writeback of r9 in the same cycle.
    ra[0] = 5'd9; ra[2] = 5'd9;
    drive(1'b1, 5'd9, 64'h99, 1'b1, 5'd9, 1'b0);
    step("t5_coll");
    idle();
    #1;
    chk("t5_busy", {63'd0, rd_busy_a[0]}, 64'd1);
    chk("t5_data_a", {32'd0, rd_data_a[31:0]}, 64'h99);
    chk("t5_data_b", rd_data_b[128 +: 64], 64'h99);
    step("t5_idle");
    drive(1'b1, 5'd9, 64'h999, 1'b0, 5'd0, 1'b0);
    $display("t5 collision done");
    step("t5_wb");

    // T6: busy on 2, 4, 6 then flush together with issue of 8.
    ra[0] = 5'd2; ra[1] = 5'd4; ra[2] = 5'd6; ra[3] = 5'd8;
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd2, 1'b0); step("t6_iss2");
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd4, 1'b0); step("t6_iss4");
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd6, 1'b0); step("t6_iss6");
    drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd8, 1'b1); step("t6_flush");
    idle();
    ra[0] = 5'd9; dbg_idx = 5'd7;
    #1;
    chk("t6_busy_b", {60'd0, rd_busy_b}, 64'd0);
    chk("t6_any_a", {63'd0, busy_any_a}, 64'd0);
    chk("t6_any_b", {63'd0, busy_any_b}, 64'd0);
    chk("t6_keep9", {32'd0, rd_data_a[31:0]}, 64'h999);
    chk("t6_keep7", dbg_b, 64'h1234);
    $display("t6 flush done");
    step("t6_idle");

    // Randomised traffic checked against the model every cycle.
    for (int n = 0; n < 400; n++) begin
      wr      = 1'($urandom_range(0, 1));
      wr_idx  = 5'($urandom_range(0, 31));
      wr_data = {$urandom, $urandom};
      iss     = ($urandom_range(0, 2) == 0);
      iss_idx = ($urandom_range(0, 5) == 0) ? wr_idx : 5'($urandom_range(0, 31));
      flush   = ($urandom_range(0, 19) == 0);
      for (int k = 0; k < 4; k++)
        ra[k] = ($urandom_range(0, 2) == 0) ? wr_idx : 5'($urandom_range(0, 31));
      dbg_idx = 5'($urandom_range(0, 31));
      step("rand");
    end
    $display("random phase done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
